// File: rtl/seg7_scan_ctrl.sv
// Double-buffered 1..8 digit seven-segment scanner with dp, leading-zero blanking, blink and ghost blanking.
// Outputs registered (1 cycle); load_ready drops while a frame is pending and rises at the frame wrap.
module seg7_scan_ctrl #(
   parameter int N_DIGITS  = 8,
   parameter int SCAN_DIV  = 12_500,
   parameter int BLANK_CYC = 16,
   parameter int BLINK_DIV = 50_000_000
) (
   input  logic                  clk_100,
   input  logic                  reset,
   input  logic [4*N_DIGITS-1:0] data_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   blink_mask,
   input  logic                  blank_lz,
   input  logic                  load_valid,
   output logic                  load_ready,
   output logic [7:0]            AN,
   output logic [7:0]            SEG,
   output logic                  frame_tick
);

   localparam int SLOT_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0]  BLANK_END  = SLOT_W'(BLANK_CYC);
   localparam logic [2:0]         DIG_LAST   = 3'(N_DIGITS - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   typedef struct packed {
      logic [4*N_DIGITS-1:0] dat;
      logic [N_DIGITS-1:0]   dp;
      logic [N_DIGITS-1:0]   blk;
      logic                  lz;
   } frame_t;

   logic [SLOT_W-1:0]  slot_q, slot_d;
   logic [2:0]         dig_q, dig_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blink_ph_q, blink_ph_d;
   logic               pending_q, pending_d;
   frame_t             shadow_q, shadow_d;
   frame_t             active_q, active_d;
   logic [7:0]         an_q, an_d;
   logic [7:0]         seg_q, seg_d;
   logic               frame_tick_q, frame_tick_d;

   logic               slot_wrap, frame_wrap, blink_wrap, load_acc;
   logic [N_DIGITS-1:0] supp;
   logic               zero_run;
   logic [3:0]         cur_nib;
   logic               cur_dp, cur_blk, cur_supp, dark;
   logic [7:0]         hex_v;

   function automatic logic [7:0] hex_seg(input logic [3:0] h);
      logic [7:0] v;
      case (h)
         4'h0: v = 8'hC0;  4'h1: v = 8'hF9;  4'h2: v = 8'hA4;  4'h3: v = 8'hB0;
         4'h4: v = 8'h99;  4'h5: v = 8'h92;  4'h6: v = 8'h82;  4'h7: v = 8'hF8;
         4'h8: v = 8'h80;  4'h9: v = 8'h90;  4'hA: v = 8'h88;  4'hB: v = 8'h83;
         4'hC: v = 8'hC6;  4'hD: v = 8'hA1;  4'hE: v = 8'h86;  default: v = 8'h8E;
      endcase
      return v;
   endfunction

   // Scan/blink counters and the shadow->active commit at frame wrap.
   always_comb begin
      slot_wrap   = (slot_q == SLOT_LAST);
      frame_wrap  = slot_wrap && (dig_q == DIG_LAST);
      slot_d      = slot_wrap ? '0 : slot_q + 1'b1;
      dig_d       = dig_q;
      if (slot_wrap) begin
         dig_d = (dig_q == DIG_LAST) ? 3'd0 : dig_q + 3'd1;
      end
      blink_wrap  = (blink_cnt_q == BLINK_LAST);
      blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
      blink_ph_d  = blink_ph_q ^ blink_wrap;

      load_acc  = load_valid && !pending_q;
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (frame_wrap && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      if (load_acc) begin
         shadow_d.dat = data_in;
         shadow_d.dp  = dp_in;
         shadow_d.blk = blink_mask;
         shadow_d.lz  = blank_lz;
         pending_d    = 1'b1;
      end
   end

   // A digit is suppressed only if it and every digit above it are blank zeros.
   always_comb begin
      supp     = '0;
      zero_run = active_q.lz;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         zero_run = zero_run && (active_q.dat[4*i +: 4] == 4'd0) && !active_q.dp[i];
         supp[i]  = zero_run;
      end
   end

   always_comb begin
      cur_nib  = 4'd0;
      cur_dp   = 1'b0;
      cur_blk  = 1'b0;
      cur_supp = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (dig_q == 3'(i)) begin
            cur_nib  = active_q.dat[4*i +: 4];
            cur_dp   = active_q.dp[i];
            cur_blk  = active_q.blk[i];
            cur_supp = supp[i];
         end
      end
      hex_v = hex_seg(cur_nib);
      dark  = (slot_q < BLANK_END) || cur_supp || (blink_ph_q && cur_blk);
      an_d  = 8'hFF;
      seg_d = 8'hFF;
      if (!dark) begin
         an_d  = ~(8'd1 << dig_q);
         seg_d = {~cur_dp, hex_v[6:0]};
      end
      frame_tick_d = frame_wrap;
   end

   always_ff @(posedge clk_100 or posedge reset) begin
      if (reset) begin
         slot_q       <= '0;
         dig_q        <= 3'd0;
         blink_cnt_q  <= '0;
         blink_ph_q   <= 1'b0;
         pending_q    <= 1'b0;
         shadow_q     <= '0;
         active_q     <= '0;
         an_q         <= 8'hFF;
         seg_q        <= 8'hFF;
         frame_tick_q <= 1'b0;
      end else begin
         slot_q       <= slot_d;
         dig_q        <= dig_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_ph_q   <= blink_ph_d;
         pending_q    <= pending_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign load_ready = ~pending_q;
   assign AN         = an_q;
   assign SEG        = seg_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised, double-buffered multiplexer for 1–8 common-anode seven-segment digits on the Nexys-4 display. It accepts a new hexadecimal frame via a valid/ready load handshake and commits it only at a scan-frame boundary, so digits never tear. Per digit, it adds decimal points, leading-zero suppression, blink masking and inter-digit ghost blanking. It drives `AN`/`SEG` directly and replaces fixed 4-digit inline scan logic in top levels.

## Interface
- `N_DIGITS`, 8: active digits, 1..8; `AN` bits ≥ `N_DIGITS` are held at 1.
- `SCAN_DIV`, 12_500: clk_100 cycles per digit slot (1 kHz per digit at 8 digits).
- `BLANK_CYC`, 16: cycles at the start of each slot with all anodes off; 1 ≤ `BLANK_CYC` < `SCAN_DIV`.
- `BLINK_DIV`, 50_000_000: blink half-period in cycles (0.5 s).

- `clk_100`, in, 1: 100 MHz clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `data_in`, in, 4*`N_DIGITS`: hex nibbles; digit *i* = `data_in[4i+3:4i]`; digit 0 is rightmost.
- `dp_in`, in, `N_DIGITS`: decimal point per digit, 1 = lit.
- `blink_mask`, in, `N_DIGITS`: 1 = digit blinks.
- `blank_lz`, in, 1: leading-zero suppression enable.
- `load_valid`, in, 1: load request.
- `load_ready`, out, 1: shadow register free.
- `AN`, out, 8: anode selects, active low.
- `SEG`, out, 8: `{dp,g,f,e,d,c,b,a}`, active low.
- `frame_tick`, out, 1: one-cycle pulse at frame start.

## Operation
- **Load.** When `load_valid & load_ready`, capture `data_in`, `dp_in`, `blink_mask` and `blank_lz` into the shadow register and set `pending`. `load_ready = ~pending`.
  - While `pending` is set, `load_valid` is ignored. No queueing.
- **Commit.** On the frame-wrap edge, if `pending`: active ← shadow, `pending` ← 0.
  - A load accepted on the wrap edge itself commits at the next wrap.
- **Scan counters.**
  - `slot_cnt` runs 0..`SCAN_DIV`-1.
  - `dig_idx` runs 0..`N_DIGITS`-1 and increments when `slot_cnt` wraps.
  - Frame wrap is the transition from (`N_DIGITS`-1, `SCAN_DIV`-1) to (0, 0).
- **Blink.** `blink_cnt` runs 0..`BLINK_DIV`-1. `blink_ph` toggles on each wrap of `blink_cnt`, free-running and independent of the frame.
- **Leading-zero suppression.** When the active `blank_lz` = 1, digit *i* is suppressed if:
  - its nibble is 0, its dp is 0, and every higher digit is also suppressed;
  - digit 0 is never suppressed.
- **Digit dark.** Digit `dig_idx` is dark if any of the following holds:
  - `slot_cnt` < `BLANK_CYC`;
  - the digit is suppressed;
  - `blink_ph` = 1 and `blink_mask[dig_idx]` = 1.
- **Outputs when dark.** `AN` = 8'hFF and `SEG` = 8'hFF.
- **Outputs when not dark.**
  - `AN` = ~(1 << `dig_idx`).
  - `SEG[6:0]` = standard hex decode, active low: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (values shown with dp off).
  - `SEG[7]` = ~dp.

## Timing
- **Reset values.**
  - Outputs: `AN`=8'hFF, `SEG`=8'hFF, `load_ready`=1, `frame_tick`=0.
  - Internal state: active and shadow registers 0, `pending`=0, all counters 0, `blink_ph`=0.
- **Output registration.** `AN`, `SEG` and `frame_tick` are registered. They reflect counter and active-register state with 1-cycle latency.
- **Frame timing.**
  - Frame length is exactly `N_DIGITS`*`SCAN_DIV` cycles.
  - `frame_tick` is high for the single cycle after the wrap edge.
  - Committed data is visible from slot 0 of that frame. The first lit cycle is `BLANK_CYC`+1 cycles after the wrap edge.
- **Load latency.** From acceptance to visible, at most one frame plus `BLANK_CYC`+1 cycles. `load_ready` rises in the same cycle as `frame_tick`.
- **Reset mid-operation.** Asserting `reset` mid-frame or mid-load discards shadow and pending data. Outputs go dark asynchronously.
- **`N_DIGITS`=1.** `dig_idx` stays at 0. Every slot wrap is a frame wrap.

## Test plan
Bench parameters: `N_DIGITS`=4, `SCAN_DIV`=8, `BLANK_CYC`=2, `BLINK_DIV`=64.

1. **Reset.** Assert `reset` for 3 cycles → `AN`=FF, `SEG`=FF, `load_ready`=1, `frame_tick`=0 throughout. After release, all digits show 0, since the active register is 0 and `blank_lz`=0.
2. **Basic scan.** Load `data_in`=16'h1234, `dp_in`=4'b0100; wait one frame. Per slot, after 2 dark cycles, expect:
   - `AN`=FE with `SEG`=99;
   - `AN`=FD with `SEG`=B0;
   - `AN`=FB with `SEG`=24 (dp lit);
   - `AN`=F7 with `SEG`=F9.
   - `frame_tick` period = 32 cycles.
3. **Handshake.**
   - Load 16'hABCD at slot 1 of a frame → `load_ready`=0 until the wrap; the display still shows old data for the rest of that frame.
   - A second `load_valid` with 16'hFFFF while pending is ignored. The next frame shows ABCD (A=88, b=83, C=C6, d=A1), never FFFF.
4. **Leading-zero suppression.** With `blank_lz`=1:
   - 16'h0050 → digits 3 and 2 keep `AN`=FF for their full slots; digit 1 shows 92, digit 0 shows C0.
   - 16'h0000 → only digit 0 lights (C0).
   - 16'h0050 with `dp_in`=4'b1000 → digit 3 lights with `SEG`=40.
5. **Blink.** `blink_mask`=4'b0010 → digit 1 is dark throughout alternate 64-cycle windows. Other digits are unaffected.
6. **Reset mid-frame.** Assert `reset` during slot 2 with a load pending → outputs go dark immediately. After release, `load_ready`=1 and the display shows all zeros; the pending data never appears.
